prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 138 +++++++++++++
 tb/tb_prog_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: streams bytes into instruction memory, then releases the PC.
// Optional running checksum of loaded bytes: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR     = 32'd0,
    parameter int          MAX_BYTES     = 256,
    parameter int          SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic [7:0]  write_data,
    output logic [31:0] write_address,
    output logic        We,
    output logic        pc_enable,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [8:0]  byte_count,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        ERROR
    } state_t;

    localparam logic [8:0] MAX_CNT  = 9'(MAX_BYTES);
    localparam logic [3:0] SET_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [8:0] cnt_q, cnt_inc;
    logic [1:0] code_d;
    logic       accept, load_clr;

    assign accept  = (state_q == LOAD) && byte_valid;
    assign cnt_inc = cnt_q + 9'd1;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        code_d   = err_code;
        load_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    load_clr = 1'b1;
                end
            end
            LOAD: begin
                settle_d = '0;
                if (accept) begin
                    if (byte_last) begin
                        if (cnt_inc[1:0] == 2'b00) begin
                            state_d = SETTLE;
                        end else begin
                            state_d = ERROR;
                            code_d  = 2'b01;
                        end
                    end else if (cnt_inc == MAX_CNT) begin
                        state_d = ERROR;
                        code_d  = 2'b10;
                    end
                end
            end
            // the cycle carrying the final write is not an idle settle cycle
            SETTLE: begin
                if (!We) begin
                    if (settle_q == SET_LAST) state_d = RUN;
                    else settle_d = settle_q + 4'd1;
                end
            end
            RUN, ERROR: begin
                if (start) begin
                    state_d  = LOAD;
                    load_clr = 1'b1;
                    code_d   = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            settle_q      <= '0;
            cnt_q         <= '0;
            We            <= 1'b0;
            write_data    <= '0;
            write_address <= BASE_ADDR;
            err_code      <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            err_code <= code_d;
            We       <= accept;
            if (load_clr) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q         <= cnt_inc;
                write_data    <= byte_data;
                write_address <= BASE_ADDR + {23'd0, cnt_q};
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else if (load_clr) sum_q <= '0;
        else if (accept) sum_q <= sum_q + byte_data;
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'd0;
`endif

    assign byte_ready = (state_q == LOAD);
    assign busy       = (state_q == LOAD) || (state_q == SETTLE);
    assign done       = (state_q == RUN);
    assign pc_enable  = (state_q == RUN);
    assign err        = (state_q == ERROR);
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: vector table for a clean load,
// hand sequences for misalignment, overflow, gaps, reset and reload.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_last = 1'b0;

    logic        rdy, we, pc, busy, done, err;
    logic [7:0]  wd, ck;
    logic [31:0] wa;
    logic [1:0]  ec;
    logic [8:0]  cnt;

    logic        o_rdy, o_we, o_pc, o_busy, o_done, o_err;
    logic [7:0]  o_wd, o_ck;
    logic [31:0] o_wa;
    logic [1:0]  o_ec;
    logic [8:0]  o_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prog_loader u_dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(rdy),
        .write_data(wd), .write_address(wa), .We(we),
        .pc_enable(pc), .busy(busy), .done(done), .err(err),
        .err_code(ec), .byte_count(cnt), .checksum(ck)
    );

    prog_loader #(
        .BASE_ADDR(32'h0000_0100),
        .MAX_BYTES(8)
    ) u_ovf (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(o_rdy),
        .write_data(o_wd), .write_address(o_wa), .We(o_we),
        .pc_enable(o_pc), .busy(o_busy), .done(o_done), .err(o_err),
        .err_code(o_ec), .byte_count(o_cnt), .checksum(o_ck)
    );

    typedef struct {
        logic        start;
        logic        valid;
        logic        last;
        logic [7:0]  data;
        logic        we;
        logic [7:0]  wd;
        logic [31:0] wa;
        logic [8:0]  cnt;
        logic        rdy;
        logic        busy;
        logic        pc;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(
        input logic st, input logic v, input logic l,
        input logic [7:0] d, input logic w, input logic [7:0] x,
        input logic [31:0] a, input logic [8:0] c,
        input logic r, input logic b, input logic p
    );
        vec_t t;
        t.start = st; t.valid = v; t.last = l; t.data = d;
        t.we = w; t.wd = x; t.wa = a; t.cnt = c;
        t.rdy = r; t.busy = b; t.pc = p;
        return t;
    endfunction

    function automatic logic [7:0] exp_ck(input logic [7:0] s);
`ifdef PROG_LOADER_CHECKSUM_EN
        return s;
`else
        return 8'h00 & s;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        byte_data = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        start = 1'b0;
        byte_valid = 1'b1;
        byte_data = d;
        byte_last = l;
        step();
        byte_valid = 1'b0;
        byte_last = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] hold;

        tbl[0] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'd0,
                    9'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++)
            tbl[k] = mk(1'b0, 1'b1, (k == 8), 8'(k), 1'b1, 8'(k),
                        32'(k - 1), 9'(k), (k < 8), 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 32'd7,
                     9'd8, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 32'd7,
                     9'd8, 1'b0, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 32'd7,
                     9'd8, 1'b0, 1'b0, 1'b1);

        // reset values
        do_reset();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wa", wa, 32'd0);
        chk("rst_wd", 32'(wd), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_err", 32'({err, ec}), 32'd0);
        chk("rst_ovf_wa", o_wa, 32'h100);

        // byte_valid outside LOAD is ignored
        send(8'h99, 1'b0);
        chk("idle_we", 32'(we), 32'd0);
        chk("idle_cnt", 32'(cnt), 32'd0);

        // clean 8-byte load via table
        for (int i = 0; i < 12; i++) begin
            start = tbl[i].start;
            byte_valid = tbl[i].valid;
            byte_data = tbl[i].data;
            byte_last = tbl[i].last;
            step();
            start = 1'b0;
            chk($sformatf("v%0d_we", i), 32'(we), 32'(tbl[i].we));
            chk($sformatf("v%0d_wd", i), 32'(wd), 32'(tbl[i].wd));
            chk($sformatf("v%0d_wa", i), wa, tbl[i].wa);
            chk($sformatf("v%0d_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_rdy", i), 32'(rdy), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].pc));
        end
        byte_valid = 1'b0;
        chk("run_ck", 32'(ck), 32'(exp_ck(8'h24)));
        chk("run_err", 32'(err), 32'd0);

        // start in RUN: reload from BASE_ADDR
        start = 1'b1;
        step();
        start = 1'b0;
        chk("reload_pc", 32'(pc), 32'd0);
        chk("reload_cnt", 32'(cnt), 32'd0);
        chk("reload_rdy", 32'(rdy), 32'd1);
        chk("reload_ck", 32'(ck), 32'd0);
        send(8'h77, 1'b0);
        chk("reload_we", 32'(we), 32'd1);
        chk("reload_wa", wa, 32'd0);
        chk("reload_wd", 32'(wd), 32'h77);
        chk("reload_ck1", 32'(ck), 32'(exp_ck(8'h77)));

        // misaligned: 6 bytes with last on the 6th
        do_reset();
        start = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            send(8'(8'h10 + k), (k == 5));
            chk($sformatf("mis_we%0d", k), 32'(we), 32'd1);
            chk($sformatf("mis_wa%0d", k), wa, 32'(k));
        end
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_code", 32'(ec), 32'd1);
        step();
        step();
        step();
        chk("mis_pc", 32'(pc), 32'd0);
        chk("mis_err_hold", 32'(err), 32'd1);
        chk("mis_rdy", 32'(rdy), 32'd0);

        // overflow on the MAX_BYTES=8 instance
        do_reset();
        start = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            send(8'(8'h30 + k), 1'b0);
            chk($sformatf("ovf_we%0d", k), 32'(o_we), 32'd1);
            chk($sformatf("ovf_wa%0d", k), o_wa, 32'(32'h100 + k));
        end
        chk("ovf_err", 32'(o_err), 32'd1);
        chk("ovf_code", 32'(o_ec), 32'd2);
        chk("ovf_rdy", 32'(o_rdy), 32'd0);
        send(8'hEE, 1'b0);
        chk("ovf_no_we", 32'(o_we), 32'd0);
        chk("ovf_cnt", 32'(o_cnt), 32'd8);
        chk("ovf_def_err", 32'(err), 32'd0);

        // valid toggling: writes only on handshakes, no address gaps
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        hold = 8'h00;
        for (int i = 0; i < 8; i++) begin
            byte_valid = (i % 2 == 0);
            byte_data = 8'(8'hA0 + i);
            byte_last = (i == 6);
            step();
            chk($sformatf("tog_we%0d", i), 32'(we), 32'(i % 2 == 0));
            if (i % 2 == 0) begin
                chk($sformatf("tog_wa%0d", i), wa, 32'(n));
                hold = 8'(8'hA0 + i);
                n++;
            end
            chk($sformatf("tog_wd%0d", i), 32'(wd), 32'(hold));
            chk($sformatf("tog_cnt%0d", i), 32'(cnt), 32'(n));
        end
        byte_valid = 1'b0;
        byte_last = 1'b0;
        chk("tog_busy", 32'(busy), 32'd1);
        chk("tog_err", 32'(err), 32'd0);

        // reset on the cycle of an acceptance
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        send(8'h44, 1'b0);
        chk("ra_we", 32'(we), 32'd1);
        byte_valid = 1'b1;
        byte_data = 8'h66;
        #2;
        rst = 1'b1;
        #1;
        chk("ra_we_now", 32'(we), 32'd0);
        chk("ra_cnt_now", 32'(cnt), 32'd0);
        chk("ra_wd_now", 32'(wd), 32'd0);
        chk("ra_wa_now", wa, 32'd0);
        chk("ra_busy_now", 32'(busy), 32'd0);
        chk("ra_rdy_now", 32'(rdy), 32'd0);
        step();
        rst = 1'b0;
        byte_valid = 1'b0;
        step();
        chk("ra_we_after", 32'(we), 32'd0);
        chk("ra_cnt_after", 32'(cnt), 32'd0);
        chk("ra_wd_after", 32'(wd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
